memshare_sched_ctrl: RTL and testbench
======================================

Name: memshare_sched_ctrl

Overview:
- Sequencing controller for the memShare request-flag → RFMU → L1PA_SPR regFile → L1PA shift path.
- Accepts one GP2 request-flag vector at a time and holds it on the RFMU input. Walks the step sequence, waiting out the regFile-read plus shift-ALU latency on each step. Captures each computed L1PA shift and hands it to the L1PA with a valid/ready handshake.
- Terminates on the isGtr "last pattern" flag or on error. Sits between the layer scheduler (upstream) and memShare_rfmu / L1PA (downstream).

Parameters:
- RQST_BITWIDTH, 5, width of request flag vector
- L1PA_SHIFT_BITWIDTH, $clog2(RQST_BITWIDTH), width of L1PA shift control
- REGFILE_RD_LAT, 1, regFile read latency in cycles (address to feedback valid)
- SHIFTDELTA_ALU_CYCLE, 1, RFMU shift-ALU pipeline depth
- MAX_STEP, 8, maximum patterns per sequence before timeout error
- STEP_BITWIDTH, $clog2(MAX_STEP+1), width of step counter

Ports:
- sys_clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- rqst_flag_i  in  RQST_BITWIDTH  request flags from upstream scheduler
- rqst_valid_i  in  1  request valid
- rqst_ready_o  out  1  controller idle; request accepted when valid & ready
- rfmu_rqstFlag_o  out  RQST_BITWIDTH  flag driven to memShare_rfmu.rqstFlag_i
- seq_step_o  out  STEP_BITWIDTH  current pattern index (regFile page offset)
- rfmu_shift_i  in  L1PA_SHIFT_BITWIDTH  memShare_rfmu.l1pa_shift_o
- rfmu_isGtr_i  in  1  memShare_rfmu.isGtr_o; 1 = last pattern
- rfmu_shiftErr_i  in  1  memShare_rfmu.shiftCal_err_o
- l1pa_shift_o  out  L1PA_SHIFT_BITWIDTH  captured shift to L1PA
- l1pa_valid_o  out  1  l1pa_shift_o valid
- l1pa_ready_i  in  1  L1PA accepts shift
- l1pa_last_o  out  1  qualifies l1pa_valid_o: final pattern of sequence
- seq_done_o  out  1  one-cycle pulse: sequence completed normally
- err_o  out  1  sticky error (shift carry or timeout)
- err_clr_i  in  1  clears err_o, returns controller to IDLE

Behaviour:
- FB_LAT = REGFILE_RD_LAT + SHIFTDELTA_ALU_CYCLE (constant). All state updates on posedge sys_clk.
- Reset (async, rst=1): state=IDLE, rfmu_rqstFlag_o=0, seq_step_o=0, l1pa_shift_o=0, l1pa_valid_o=0, l1pa_last_o=0, seq_done_o=0, err_o=0, wait counter=0. rqst_ready_o = (state==IDLE) & ~err_o, so it is 1 after reset. Reset mid-sequence discards the sequence with no further output.
- IDLE: on rqst_valid_i & rqst_ready_o, latch the flag into rfmu_rqstFlag_o, set seq_step_o=0, go to WAIT with counter=FB_LAT-1. An all-zero flag completes immediately: seq_done_o pulses next cycle, no L1PA output.
- WAIT: rfmu_rqstFlag_o and seq_step_o are held stable. Counter decrements. When the counter reaches 0, the next edge samples rfmu_shift_i, rfmu_isGtr_i and rfmu_shiftErr_i.
  - If rfmu_shiftErr_i=1: go to ERR, set err_o=1, no valid issued.
  - Otherwise: l1pa_shift_o ← rfmu_shift_i, l1pa_last_o ← rfmu_isGtr_i, l1pa_valid_o ← 1, go to EMIT.
- EMIT: hold all outputs until l1pa_ready_i=1. On the handshake edge l1pa_valid_o←0, then:
  - If l1pa_last_o=1: seq_done_o=1 for one cycle, go to IDLE.
  - Else if seq_step_o==MAX_STEP-1: go to ERR, err_o=1.
  - Else: seq_step_o+1, counter=FB_LAT-1, go to WAIT.
- Per-step latency = FB_LAT+1 cycles, plus backpressure stall. A ready already high in the first EMIT cycle costs no extra cycle beyond that.
- ERR: rqst_ready_o=0, l1pa_valid_o=0, rfmu_rqstFlag_o held. err_clr_i=1 clears err_o and returns to IDLE on the next edge. err_clr_i in any other state is ignored.
- rqst_valid_i outside IDLE is ignored; upstream must hold it until ready.

Optional Feature:
- Macro MEMSHARE_SCHED_PERF_EN.
- Defined: adds outputs perf_seqCnt_o (16b, completed sequences) and perf_stallCnt_o (16b, EMIT cycles with l1pa_ready_i=0). Both saturate at 16'hFFFF and reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package memshare_sched_pkg: FSM state enum (IDLE, WAIT, EMIT, ERR), FB_LAT derivation function, default widths.
- One natural sub-module: memshare_sched_waitcnt, a loadable down-counter with a zero flag, used for the FB_LAT wait.

Test Plan:
- Single-pattern: FB_LAT=2, flag=5'b00101, isGtr=1 at sample, shift=3. Expect l1pa_valid_o on cycle 3 after accept, shift=3, last=1, seq_done_o pulse after ready.
- Three-pattern, ready tied 1: isGtr=0,0,1 with shifts 1,2,0. Expect seq_step_o 0→1→2, three valids spaced 3 cycles apart, last only on the third.
- Backpressure: l1pa_ready_i low for 4 cycles in EMIT. Expect shift/valid/last held constant and no step advance; perf_stallCnt_o=4 with MEMSHARE_SCHED_PERF_EN.
- Shift error: rfmu_shiftErr_i=1 on step 1. Expect no valid for that step, err_o=1, rqst_ready_o=0. Then err_clr_i pulse: IDLE and ready=1 next cycle.
- Timeout: MAX_STEP=4, isGtr always 0. Expect 4 valids, then err_o=1, no seq_done_o.
- Async reset asserted mid-WAIT: all outputs zero immediately (no clock edge required), rqst_ready_o=1 after release; a new request completes normally.

Source files
------------

// File: rtl/memshare_sched_pkg.sv
// Shared types and constants for the memShare sequencing controller.
// Optional perf counters are enabled with MEMSHARE_SCHED_PERF_EN.
package memshare_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    EMIT = 2'd2,
    ERR  = 2'd3
  } sched_state_t;

  localparam int DEF_RQST_BITWIDTH        = 5;
  localparam int DEF_REGFILE_RD_LAT       = 1;
  localparam int DEF_SHIFTDELTA_ALU_CYCLE = 1;
  localparam int DEF_MAX_STEP             = 8;
  localparam int PERF_W                   = 16;

  // Cycles from a stable regFile page offset to a valid RFMU shift result.
  function automatic int fb_lat(input int rd_lat, input int alu_cycle);
    return rd_lat + alu_cycle;
  endfunction

endpackage

// File: rtl/memshare_sched_waitcnt.sv
// Loadable down-counter with a zero flag; times the feedback latency of each step.
module memshare_sched_waitcnt #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_reg;

  // Load wins over decrement; the count parks at zero until the next load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - CNT_W'(1);
    end
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/memshare_sched_ctrl.sv
// Sequences request flag -> RFMU -> regFile -> L1PA shift handoff, one step per pattern.
// Define MEMSHARE_SCHED_PERF_EN to add saturating sequence/stall counters.
module memshare_sched_ctrl
  import memshare_sched_pkg::*;
#(
  parameter int RQST_BITWIDTH        = DEF_RQST_BITWIDTH,
  parameter int L1PA_SHIFT_BITWIDTH  = $clog2(RQST_BITWIDTH),
  parameter int REGFILE_RD_LAT       = DEF_REGFILE_RD_LAT,
  parameter int SHIFTDELTA_ALU_CYCLE = DEF_SHIFTDELTA_ALU_CYCLE,
  parameter int MAX_STEP             = DEF_MAX_STEP,
  parameter int STEP_BITWIDTH        = $clog2(MAX_STEP + 1)
) (
  input  logic                           sys_clk,
  input  logic                           rst,
  input  logic [RQST_BITWIDTH-1:0]       rqst_flag_i,
  input  logic                           rqst_valid_i,
  output logic                           rqst_ready_o,
  output logic [RQST_BITWIDTH-1:0]       rfmu_rqstFlag_o,
  output logic [STEP_BITWIDTH-1:0]       seq_step_o,
  input  logic [L1PA_SHIFT_BITWIDTH-1:0] rfmu_shift_i,
  input  logic                           rfmu_isGtr_i,
  input  logic                           rfmu_shiftErr_i,
  output logic [L1PA_SHIFT_BITWIDTH-1:0] l1pa_shift_o,
  output logic                           l1pa_valid_o,
  input  logic                           l1pa_ready_i,
  output logic                           l1pa_last_o,
  output logic                           seq_done_o,
  output logic                           err_o,
  input  logic                           err_clr_i
`ifdef MEMSHARE_SCHED_PERF_EN
  ,
  output logic [PERF_W-1:0]              perf_seqCnt_o,
  output logic [PERF_W-1:0]              perf_stallCnt_o
`endif
);

  localparam int FB_LAT = fb_lat(REGFILE_RD_LAT, SHIFTDELTA_ALU_CYCLE);
  localparam int CNT_W  = $clog2(FB_LAT + 1);
  localparam logic [CNT_W-1:0]         CNT_LOAD  = CNT_W'(FB_LAT - 1);
  localparam logic [STEP_BITWIDTH-1:0] LAST_STEP = STEP_BITWIDTH'(MAX_STEP - 1);
  localparam logic [STEP_BITWIDTH-1:0] STEP_ONE  = STEP_BITWIDTH'(1);

  sched_state_t state_reg;

  logic accept;
  logic emit_hs;
  logic step_more;
  logic cnt_load;
  logic cnt_dec;
  logic cnt_zero;

  assign rqst_ready_o = (state_reg == IDLE) & ~err_o;
  assign accept       = rqst_valid_i & rqst_ready_o;
  assign emit_hs      = (state_reg == EMIT) & l1pa_ready_i;
  assign step_more    = ~l1pa_last_o & (seq_step_o != LAST_STEP);
  // Reload on every transition into WAIT: a non-empty accept or a continuing handshake.
  assign cnt_load     = (accept & (|rqst_flag_i)) | (emit_hs & step_more);
  assign cnt_dec      = (state_reg == WAIT);

  memshare_sched_waitcnt #(
    .CNT_W (CNT_W)
  ) u_waitcnt (
    .clk      (sys_clk),
    .rst      (rst),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (CNT_LOAD),
    .zero     (cnt_zero)
  );

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      rfmu_rqstFlag_o <= '0;
      seq_step_o      <= '0;
      l1pa_shift_o    <= '0;
      l1pa_valid_o    <= 1'b0;
      l1pa_last_o     <= 1'b0;
      seq_done_o      <= 1'b0;
      err_o           <= 1'b0;
    end else begin
      seq_done_o <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            rfmu_rqstFlag_o <= rqst_flag_i;
            seq_step_o      <= '0;
            // An empty request has no patterns to walk.
            if (|rqst_flag_i) begin
              state_reg <= WAIT;
            end else begin
              seq_done_o <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (cnt_zero) begin
            if (rfmu_shiftErr_i) begin
              err_o     <= 1'b1;
              state_reg <= ERR;
            end else begin
              l1pa_shift_o <= rfmu_shift_i;
              l1pa_last_o  <= rfmu_isGtr_i;
              l1pa_valid_o <= 1'b1;
              state_reg    <= EMIT;
            end
          end
        end
        EMIT: begin
          if (l1pa_ready_i) begin
            l1pa_valid_o <= 1'b0;
            if (l1pa_last_o) begin
              seq_done_o <= 1'b1;
              state_reg  <= IDLE;
            end else if (seq_step_o == LAST_STEP) begin
              err_o     <= 1'b1;
              state_reg <= ERR;
            end else begin
              seq_step_o <= seq_step_o + STEP_ONE;
              state_reg  <= WAIT;
            end
          end
        end
        ERR: begin
          if (err_clr_i) begin
            err_o     <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef MEMSHARE_SCHED_PERF_EN
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      perf_seqCnt_o   <= '0;
      perf_stallCnt_o <= '0;
    end else begin
      if (seq_done_o && (perf_seqCnt_o != {PERF_W{1'b1}})) begin
        perf_seqCnt_o <= perf_seqCnt_o + PERF_W'(1);
      end
      if ((state_reg == EMIT) && !l1pa_ready_i && (perf_stallCnt_o != {PERF_W{1'b1}})) begin
        perf_stallCnt_o <= perf_stallCnt_o + PERF_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_memshare_sched_ctrl.sv
// Scoreboard bench for memshare_sched_ctrl: bench plays RFMU and L1PA, checks against a sequence model.
// Perf counter checks are compiled in when MEMSHARE_SCHED_PERF_EN is defined.
module tb_memshare_sched_ctrl;

  localparam int RQ_W    = 5;
  localparam int SH_W    = 3;
  localparam int RD_LAT  = 1;
  localparam int ALU_CYC = 1;
  localparam int MSTEP   = 4;
  localparam int ST_W    = $clog2(MSTEP + 1);
  localparam int FB_LAT  = RD_LAT + ALU_CYC;

  localparam int EV_SHIFT = 0;
  localparam int EV_DONE  = 1;
  localparam int EV_ERR   = 2;

  logic            sys_clk = 1'b0;
  logic            rst     = 1'b1;
  logic [RQ_W-1:0] rqst_flag_i = '0;
  logic            rqst_valid_i = 1'b0;
  logic            rqst_ready_o;
  logic [RQ_W-1:0] rfmu_rqstFlag_o;
  logic [ST_W-1:0] seq_step_o;
  logic [SH_W-1:0] rfmu_shift_i = '0;
  logic            rfmu_isGtr_i = 1'b0;
  logic            rfmu_shiftErr_i = 1'b0;
  logic [SH_W-1:0] l1pa_shift_o;
  logic            l1pa_valid_o;
  logic            l1pa_ready_i = 1'b1;
  logic            l1pa_last_o;
  logic            seq_done_o;
  logic            err_o;
  logic            err_clr_i = 1'b0;
`ifdef MEMSHARE_SCHED_PERF_EN
  logic [15:0]     perf_seqCnt_o;
  logic [15:0]     perf_stallCnt_o;
`endif

  memshare_sched_ctrl #(
    .RQST_BITWIDTH        (RQ_W),
    .L1PA_SHIFT_BITWIDTH  (SH_W),
    .REGFILE_RD_LAT       (RD_LAT),
    .SHIFTDELTA_ALU_CYCLE (ALU_CYC),
    .MAX_STEP             (MSTEP),
    .STEP_BITWIDTH        (ST_W)
  ) dut (
    .sys_clk         (sys_clk),
    .rst             (rst),
    .rqst_flag_i     (rqst_flag_i),
    .rqst_valid_i    (rqst_valid_i),
    .rqst_ready_o    (rqst_ready_o),
    .rfmu_rqstFlag_o (rfmu_rqstFlag_o),
    .seq_step_o      (seq_step_o),
    .rfmu_shift_i    (rfmu_shift_i),
    .rfmu_isGtr_i    (rfmu_isGtr_i),
    .rfmu_shiftErr_i (rfmu_shiftErr_i),
    .l1pa_shift_o    (l1pa_shift_o),
    .l1pa_valid_o    (l1pa_valid_o),
    .l1pa_ready_i    (l1pa_ready_i),
    .l1pa_last_o     (l1pa_last_o),
    .seq_done_o      (seq_done_o),
    .err_o           (err_o),
    .err_clr_i       (err_clr_i)
`ifdef MEMSHARE_SCHED_PERF_EN
    ,
    .perf_seqCnt_o   (perf_seqCnt_o),
    .perf_stallCnt_o (perf_stallCnt_o)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int kind;
    int shift;
    int last;
    int step;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  exp_seq = 0;
  int  exp_stall = 0;
  int  ready_mode = 0;   // 0: always ready, 1: random, 2: stall 4 cycles per valid
  logic [SH_W-1:0] plan_shift[8];
  bit  plan_gtr[8];
  bit  plan_err[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_ev(input int kind);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event actual_kind=%0d required=none t=%0t", kind, $time);
      return;
    end
    e = exp_q.pop_front();
    chk("event_kind", kind, e.kind);
    if (kind == EV_SHIFT && e.kind == EV_SHIFT) begin
      chk("l1pa_shift", l1pa_shift_o, e.shift);
      chk("l1pa_last", l1pa_last_o, e.last);
      chk("seq_step", seq_step_o, e.step);
    end
  endtask

  // Reference model: walk the plan by the sequencing rules and list the expected events.
  task automatic build_model(input logic [RQ_W-1:0] flag);
    ev_t e;
    if (flag == '0) begin
      e = '{EV_DONE, 0, 0, 0};
      exp_q.push_back(e);
      return;
    end
    for (int s = 0; s < MSTEP; s++) begin
      if (plan_err[s]) begin
        e = '{EV_ERR, 0, 0, s};
        exp_q.push_back(e);
        return;
      end
      e = '{EV_SHIFT, int'(plan_shift[s]), int'(plan_gtr[s]), s};
      exp_q.push_back(e);
      if (plan_gtr[s]) begin
        e = '{EV_DONE, 0, 0, s};
        exp_q.push_back(e);
        return;
      end
    end
    e = '{EV_ERR, 0, 0, MSTEP - 1};
    exp_q.push_back(e);
  endtask

  task automatic clear_plan();
    for (int s = 0; s < 8; s++) begin
      plan_shift[s] = '0;
      plan_gtr[s]   = 1'b0;
      plan_err[s]   = 1'b0;
    end
  endtask

  task automatic set_step(input int s, input int sh, input bit gtr, input bit er);
    plan_shift[s] = SH_W'(sh);
    plan_gtr[s]   = gtr;
    plan_err[s]   = er;
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic issue(input logic [RQ_W-1:0] flag);
    int n = 0;
    while (!rqst_ready_o && n < 50) begin
      tick();
      n++;
    end
    if (!rqst_ready_o) chk("ready_wait_timeout", 0, 1);
    build_model(flag);
    rqst_flag_i  = flag;
    rqst_valid_i = 1'b1;
    tick();
    rqst_valid_i = 1'b0;
  endtask

  task automatic run_seq(input logic [RQ_W-1:0] flag);
    int n = 0;
    issue(flag);
    while (!seq_done_o && !err_o && n < 300) begin
      tick();
      n++;
    end
    if (!seq_done_o && !err_o) chk("terminal_timeout", 0, 1);
    if (err_o) begin
      chk("ready_in_err", rqst_ready_o, 0);
      err_clr_i = 1'b1;
      tick();
      err_clr_i = 1'b0;
      chk("err_cleared", err_o, 0);
      chk("ready_after_clr", rqst_ready_o, 1);
    end
    tick();
  endtask

  // RFMU stand-in: results depend only on the held page offset.
  initial begin
    forever begin
      @(posedge sys_clk);
      #1;
      rfmu_shift_i    = plan_shift[seq_step_o];
      rfmu_isGtr_i    = plan_gtr[seq_step_o];
      rfmu_shiftErr_i = plan_err[seq_step_o];
    end
  end

  // L1PA stand-in with selectable backpressure.
  initial begin
    int  stall_left = 0;
    bit  seen = 1'b0;
    forever begin
      @(posedge sys_clk);
      #1;
      if (l1pa_valid_o && !seen) stall_left = (ready_mode == 2) ? 4 : 0;
      seen = l1pa_valid_o;
      case (ready_mode)
        0: l1pa_ready_i = 1'b1;
        1: l1pa_ready_i = 1'($urandom_range(0, 1));
        default: begin
          l1pa_ready_i = (stall_left == 0);
          if (stall_left > 0) stall_left--;
        end
      endcase
    end
  end

  // Monitor: samples on the falling edge and pops the scoreboard on every DUT event.
  initial begin
    int cyc = 0;
    int last_evt = -100;
    logic prev_valid = 1'b0, prev_ready = 1'b0, prev_err = 1'b0, prev_last = 1'b0;
    logic [SH_W-1:0] prev_shift = '0;
    logic [ST_W-1:0] prev_step = '0;
    forever begin
      @(negedge sys_clk);
      cyc++;
      if (rst) begin
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_err   = 1'b0;
      end else begin
        if (rqst_valid_i && rqst_ready_o) last_evt = cyc;
        if (l1pa_valid_o && !prev_valid) chk("step_latency", cyc - last_evt, FB_LAT + 1);
        if (prev_valid && !prev_ready) begin
          chk("hold_valid", l1pa_valid_o, 1);
          chk("hold_shift", l1pa_shift_o, prev_shift);
          chk("hold_last", l1pa_last_o, prev_last);
          chk("hold_step", seq_step_o, prev_step);
        end
        if (l1pa_valid_o && !l1pa_ready_i) exp_stall++;
        if (l1pa_valid_o && l1pa_ready_i) begin
          expect_ev(EV_SHIFT);
          last_evt = cyc;
        end
        if (seq_done_o) begin
          expect_ev(EV_DONE);
          exp_seq++;
        end
        if (err_o && !prev_err) expect_ev(EV_ERR);
        if (err_o) chk("no_valid_in_err", l1pa_valid_o, 0);
        prev_valid = l1pa_valid_o;
        prev_ready = l1pa_ready_i;
        prev_err   = err_o;
        prev_last  = l1pa_last_o;
        prev_shift = l1pa_shift_o;
        prev_step  = seq_step_o;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [RQ_W-1:0] flag;
`ifdef MEMSHARE_SCHED_PERF_EN
    logic [15:0] stall_before;
`endif
    clear_plan();
    #12;
    chk("rst_valid", l1pa_valid_o, 0);
    chk("rst_step", seq_step_o, 0);
    chk("rst_flag", rfmu_rqstFlag_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_done", seq_done_o, 0);
    chk("rst_ready", rqst_ready_o, 1);
    tick();
    rst = 1'b0;
    tick();

    // Single pattern, last on first sample.
    set_step(0, 3, 1'b1, 1'b0);
    run_seq(5'b00101);

    // Three patterns with ready always high.
    clear_plan();
    set_step(0, 1, 1'b0, 1'b0);
    set_step(1, 2, 1'b0, 1'b0);
    set_step(2, 0, 1'b1, 1'b0);
    run_seq(5'b10110);

    // Backpressure of four cycles.
    clear_plan();
    set_step(0, 6, 1'b1, 1'b0);
    ready_mode = 2;
`ifdef MEMSHARE_SCHED_PERF_EN
    stall_before = perf_stallCnt_o;
`endif
    run_seq(5'b01000);
`ifdef MEMSHARE_SCHED_PERF_EN
    chk("perf_stall_delta", perf_stallCnt_o - stall_before, 4);
`endif
    ready_mode = 0;

    // Shift error on step 1.
    clear_plan();
    set_step(0, 2, 1'b0, 1'b0);
    set_step(1, 5, 1'b0, 1'b1);
    run_seq(5'b00011);

    // Timeout: never last.
    clear_plan();
    for (int s = 0; s < MSTEP; s++) set_step(s, s + 1, 1'b0, 1'b0);
    run_seq(5'b11111);

    // Empty request.
    clear_plan();
    run_seq(5'b00000);

    // Asynchronous reset in WAIT.
    set_step(0, 4, 1'b1, 1'b0);
    issue(5'b01101);
    #3;
    rst = 1'b1;
    exp_q.delete();
    exp_seq   = 0;
    exp_stall = 0;
    #1;
    chk("arst_flag", rfmu_rqstFlag_o, 0);
    chk("arst_step", seq_step_o, 0);
    chk("arst_valid", l1pa_valid_o, 0);
    chk("arst_shift", l1pa_shift_o, 0);
    chk("arst_err", err_o, 0);
    tick();
    tick();
    rst = 1'b0;
    chk("arst_ready", rqst_ready_o, 1);
    tick();
    run_seq(5'b01101);

    // Randomized sequences with random backpressure.
    ready_mode = 1;
    for (int i = 0; i < 40; i++) begin
      for (int s = 0; s < 8; s++) begin
        plan_shift[s] = SH_W'($urandom_range(0, 7));
        plan_gtr[s]   = ($urandom_range(0, 2) == 0);
        plan_err[s]   = ($urandom_range(0, 11) == 0);
      end
      flag = RQ_W'($urandom_range(1, 31));
      if ($urandom_range(0, 7) == 0) flag = '0;
      run_seq(flag);
    end
    ready_mode = 0;

    tick();
    tick();
    tick();
    chk("scoreboard_empty", exp_q.size(), 0);
`ifdef MEMSHARE_SCHED_PERF_EN
    chk("perf_seq_total", perf_seqCnt_o, exp_seq);
    chk("perf_stall_total", perf_stallCnt_o, exp_stall);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
